// File: rtl/execute_stage_mdu.sv
// RV32 EX stage: forwarding, ALU, branch/jump resolution and a
// multi-cycle RV32M unit that holds the pipeline through stallE.
module execute_stage_mdu #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter bit ENABLE_M   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validE,
  input  logic            flushE,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] rd1E,
  input  logic [XLEN-1:0] rd2E,
  input  logic [XLEN-1:0] extImmE,
  input  logic [3:0]      aluControlE,
  input  logic            aluSrcE,
  input  logic            mdEnE,
  input  logic [2:0]      mdOpE,
  input  logic            branchE,
  input  logic [2:0]      branchTypeE,
  input  logic            jumpE,
  input  logic            jalrE,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] aluResultM,
  input  logic [XLEN-1:0] resultW,
  output logic [XLEN-1:0] aluResultE,
  output logic [XLEN-1:0] writeDataE,
  output logic [XLEN-1:0] branchTargetE,
  output logic            branchTakenE,
  output logic            stallE
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] jsum;
  logic [XLEN-1:0] md_res;
  logic            md_stall;
  logic            md_done;
  logic            cond;

  always_comb begin
    unique case (forwardAE)
      2'b10:   srcA = aluResultM;
      2'b01:   srcA = resultW;
      default: srcA = rd1E;
    endcase
    unique case (forwardBE)
      2'b10:   fwdB = aluResultM;
      2'b01:   fwdB = resultW;
      default: fwdB = rd2E;
    endcase
  end

  assign srcB       = aluSrcE ? extImmE : fwdB;
  assign writeDataE = fwdB;

  always_comb begin
    alu_out = '0;
    unique case (aluControlE)
      4'd0:    alu_out = srcA + srcB;
      4'd1:    alu_out = srcA - srcB;
      4'd2:    alu_out = srcA & srcB;
      4'd3:    alu_out = srcA | srcB;
      4'd4:    alu_out = srcA ^ srcB;
      4'd5:    alu_out = {{(XLEN-1){1'b0}},
                          $signed(srcA) < $signed(srcB)};
      4'd6:    alu_out = {{(XLEN-1){1'b0}}, srcA < srcB};
      4'd7:    alu_out = srcA << srcB[SW-1:0];
      4'd8:    alu_out = srcA >> srcB[SW-1:0];
      4'd9:    alu_out = $signed(srcA) >>> srcB[SW-1:0];
      4'd10:   alu_out = srcB;
      default: alu_out = '0;
    endcase
  end

  // compares always use rs2, never the immediate
  always_comb begin
    unique case (branchTypeE)
      3'b000:  cond = srcA == fwdB;
      3'b001:  cond = srcA != fwdB;
      3'b100:  cond = $signed(srcA) < $signed(fwdB);
      3'b101:  cond = $signed(srcA) >= $signed(fwdB);
      3'b110:  cond = srcA < fwdB;
      3'b111:  cond = srcA >= fwdB;
      default: cond = 1'b0;
    endcase
  end

  assign jsum = srcA + extImmE;

  assign branchTargetE = jalrE
    ? (jsum & ~{{(XLEN-1){1'b0}}, 1'b1})
    : pcE + extImmE;

  assign branchTakenE = ~rst & validE & ~flushE &
    ((branchE & cond) | jumpE | jalrE);

  assign aluResultE = md_done ? md_res
    : (jumpE | jalrE) ? pcE + XLEN'(4)
    : alu_out;

  assign stallE = md_stall;

  if (ENABLE_M) begin : g_mdu
    localparam int CMAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   rr;
    logic [XLEN-1:0]   res;
    logic              qneg;
    logic              rneg;
    logic              div_s;
    logic              a_neg;
    logic              b_neg;
    logic              div0;
    logic              ovf;
    logic              a_s;
    logic              b_s;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   spec;
    logic [XLEN-1:0]   q_nx;
    logic [XLEN-1:0]   r_nx;
    logic [XLEN-1:0]   d_res;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     r_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] prod;

    assign div_s = ~mdOpE[0];
    assign a_neg = div_s & srcA[XLEN-1];
    assign b_neg = div_s & fwdB[XLEN-1];
    assign a_mag = a_neg ? -srcA : srcA;
    assign b_mag = b_neg ? -fwdB : fwdB;
    assign div0  = fwdB == '0;
    assign ovf   = div_s & (srcA == MIN_INT) & (fwdB == '1);
    assign spec  = div0
      ? (mdOpE[1] ? srcA : '1)
      : (mdOpE[1] ? '0 : MIN_INT);

    // opa doubles as the quotient shift register while dividing
    assign r_sh  = {rr, opa[XLEN-1]};
    assign diff  = r_sh - {1'b0, opb};
    assign r_nx  = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign q_nx  = {opa[XLEN-2:0], ~diff[XLEN]};
    assign d_res = op[1]
      ? (rneg ? -r_nx : r_nx)
      : (qneg ? -q_nx : q_nx);

    assign a_s  = op[1:0] != 2'b11;
    assign b_s  = op[1:0] == 2'b01;
    assign prod = {{XLEN{a_s & opa[XLEN-1]}}, opa} *
                  {{XLEN{b_s & opb[XLEN-1]}}, opb};
    assign mul_res = (op[1:0] == 2'b00)
      ? prod[XLEN-1:0]
      : prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
        op    <= '0;
        opa   <= '0;
        opb   <= '0;
        rr    <= '0;
        res   <= '0;
        qneg  <= 1'b0;
        rneg  <= 1'b0;
      end else if (flushE) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (validE & mdEnE) begin
              op  <= mdOpE;
              cnt <= '0;
              rr  <= '0;
              if (!mdOpE[2]) begin
                opa   <= srcA;
                opb   <= fwdB;
                state <= MUL;
              end else if (div0 | ovf) begin
                res   <= spec;
                state <= DONE;
              end else begin
                opa   <= a_mag;
                opb   <= b_mag;
                qneg  <= a_neg ^ b_neg;
                rneg  <= a_neg;
                state <= DIV;
              end
            end
          end
          MUL: begin
            if (cnt == MUL_LAST) begin
              res   <= mul_res;
              state <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DIV: begin
            opa <= q_nx;
            rr  <= r_nx;
            if (cnt == DIV_LAST) begin
              res   <= d_res;
              state <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DONE: state <= IDLE;
        endcase
      end
    end

    assign md_stall = ~rst & ~flushE &
      (((state == IDLE) & validE & mdEnE) |
       (state == MUL) | (state == DIV));
    assign md_done = state == DONE;
    assign md_res  = res;
  end else begin : g_nomdu
    assign md_stall = 1'b0;
    assign md_done  = 1'b0;
    assign md_res   = '0;
  end

endmodule
